// File: rtl/sap1_pkg.sv
// Shared types and constants for the SAP-1 fetch front end.
package sap1_pkg;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_LDA = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
    localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        IR     = 3'd1,
        DECODE = 3'd2,
        OPER   = 3'd3,
        ISSUE  = 3'd4,
        HALT   = 3'd5
    } fetch_state_e;

    // Opcodes that need a second RAM read for their operand.
    function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
        return (opc == OP_LDA) || (opc == OP_ADD) || (opc == OP_SUB);
    endfunction

endpackage

// File: rtl/sap1_prog_counter.sv
// Program counter: ADDR_W-bit wrap counter with load priority over increment.
module sap1_prog_counter #(
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              inc_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    output logic [ADDR_W-1:0] cnt_o
);

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    // Next count: a load (jump) overrides the sequential increment.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + ADDR_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/sap1_fetch_unit.sv
// SAP-1 fetch/decode sequencer issuing {opcode, operand} over valid/ready.
// Optional JMP (opcode 0x6) is enabled by defining SAP1_FETCH_JMP_EN.
module sap1_fetch_unit
    import sap1_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic              ram_cen_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic [DATA_W-1:0] ram_data_i,
    output logic              op_valid_o,
    input  logic              op_ready_i,
    output logic [OPC_W-1:0]  op_code_o,
    output logic [DATA_W-1:0] op_data_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              halted_o
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] opnd_q;
    logic [OPC_W-1:0]  code_q;
    logic              cen_q;
    logic              valid_q;
    logic              halted_q;

    logic [ADDR_W-1:0] pc_s;
    logic              pc_inc_s;
    logic              pc_load_s;
    logic [OPC_W-1:0]  ir_opc_s;

    assign ir_opc_s = ir_q[DATA_W-1:ADDR_W];

    // PC control: advance in FETCH, optionally reload from the IR operand on JMP.
    always_comb begin
        pc_inc_s  = (state_q == FETCH);
        pc_load_s = 1'b0;
`ifdef SAP1_FETCH_JMP_EN
        if ((state_q == DECODE) && (ir_opc_s == OP_JMP)) begin
            pc_load_s = 1'b1;
        end else begin
            pc_load_s = 1'b0;
        end
`endif
    end

    sap1_prog_counter #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .inc_i      (pc_inc_s),
        .load_i     (pc_load_s),
        .load_val_i (ir_q[ADDR_W-1:0]),
        .cnt_o      (pc_s)
    );

    // Sequencer; RAM enable, valid and halt are set one edge ahead of their state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= FETCH;
            mar_q    <= '0;
            ir_q     <= '0;
            opnd_q   <= '0;
            code_q   <= '0;
            cen_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    mar_q   <= pc_s;
                    cen_q   <= 1'b1;
                    state_q <= IR;
                end
                IR: begin
                    ir_q    <= ram_data_i;
                    cen_q   <= 1'b0;
                    state_q <= DECODE;
                end
                DECODE: begin
                    if (is_mem_op(ir_opc_s)) begin
                        mar_q   <= ir_q[ADDR_W-1:0];
                        cen_q   <= 1'b1;
                        state_q <= OPER;
                    end else if (ir_opc_s == OP_OUT) begin
                        opnd_q  <= '0;
                        code_q  <= OP_OUT;
                        valid_q <= 1'b1;
                        state_q <= ISSUE;
                    end else if (ir_opc_s == OP_HLT) begin
                        halted_q <= 1'b1;
                        state_q  <= HALT;
                    end else begin
                        // NOP, and JMP whose PC reload happens in the counter.
                        state_q <= FETCH;
                    end
                end
                OPER: begin
                    opnd_q  <= ram_data_i;
                    code_q  <= ir_opc_s;
                    cen_q   <= 1'b0;
                    valid_q <= 1'b1;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    if (valid_q && op_ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= FETCH;
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign ram_cen_o  = cen_q;
    assign ram_addr_o = mar_q;
    assign op_valid_o = valid_q;
    assign op_code_o  = code_q;
    assign op_data_o  = opnd_q;
    assign pc_o       = pc_s;
    assign halted_o   = halted_q;

endmodule

// File: tb/tb_sap1_fetch_unit.sv
// Self-checking bench for sap1_fetch_unit: per-cycle reference model plus directed pins.
module tb_sap1_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ram_cen;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic       op_valid;
    logic       op_ready = 1'b0;
    logic [3:0] op_code;
    logic [7:0] op_data;
    logic [3:0] pc;
    logic       halted;

    logic [7:0] ram [16];
    assign ram_data = ram[ram_addr];

    sap1_fetch_unit #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .ram_cen_o  (ram_cen),
        .ram_addr_o (ram_addr),
        .ram_data_i (ram_data),
        .op_valid_o (op_valid),
        .op_ready_i (op_ready),
        .op_code_o  (op_code),
        .op_data_o  (op_data),
        .pc_o       (pc),
        .halted_o   (halted)
    );

    always #5 clk = ~clk;

`ifdef SAP1_FETCH_JMP_EN
    localparam bit JMP_EN = 1'b1;
`else
    localparam bit JMP_EN = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within the current instruction, counted in clocks
    // since it started fetching (fetch=0, word read=1, decode=2, operand=3, issue=4).
    int         m_k;
    logic       m_cen, m_valid, m_halt;
    logic [3:0] m_pc, m_mar, m_code;
    logic [7:0] m_ins, m_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k <= 0; m_cen <= 1'b0; m_valid <= 1'b0; m_halt <= 1'b0;
            m_pc <= 4'h0; m_mar <= 4'h0; m_code <= 4'h0; m_ins <= 8'h00; m_data <= 8'h00;
        end else if (!m_halt) begin
            case (m_k)
                0: begin m_mar <= m_pc; m_pc <= m_pc + 4'd1; m_cen <= 1'b1; m_k <= 1; end
                1: begin m_ins <= ram[m_mar]; m_cen <= 1'b0; m_k <= 2; end
                2: begin
                    if (m_ins[7:4] <= 4'h2) begin
                        m_mar <= m_ins[3:0]; m_cen <= 1'b1; m_k <= 3;
                    end else if (m_ins[7:4] == 4'hE) begin
                        m_valid <= 1'b1; m_code <= 4'hE; m_data <= 8'h00; m_k <= 4;
                    end else if (m_ins[7:4] == 4'hF) begin
                        m_halt <= 1'b1;
                    end else if (JMP_EN && m_ins[7:4] == 4'h6) begin
                        m_pc <= m_ins[3:0]; m_k <= 0;
                    end else begin
                        m_k <= 0;
                    end
                end
                3: begin
                    m_data <= ram[m_mar]; m_code <= m_ins[7:4];
                    m_valid <= 1'b1; m_cen <= 1'b0; m_k <= 4;
                end
                4: if (op_ready) begin m_valid <= 1'b0; m_k <= 0; end
                default: m_k <= 0;
            endcase
        end
    end

    // Per-cycle comparison and logging, index = clocks since reset release.
    int         cyc = 0;
    logic [3:0] addr_log [256];
    logic [3:0] pc_log   [256];
    logic [3:0] code_log [256];
    logic [7:0] data_log [256];
    logic       valid_log[256];
    logic       cen_log  [256];
    logic       halt_log [256];

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cen", ram_cen, m_cen);
            chk("addr", ram_addr, m_mar);
            chk("valid", op_valid, m_valid);
            chk("pc", pc, m_pc);
            chk("halted", halted, m_halt);
            if (m_valid) begin
                chk("code", op_code, m_code);
                chk("data", op_data, m_data);
            end
            if (cyc < 256) begin
                addr_log[cyc] <= ram_addr; pc_log[cyc] <= pc; code_log[cyc] <= op_code;
                data_log[cyc] <= op_data; valid_log[cyc] <= op_valid;
                cen_log[cyc] <= ram_cen; halt_log[cyc] <= halted;
            end
            cyc <= cyc + 1;
        end else begin
            cyc <= 0;
        end
    end

    int hs_cnt = 0;
    int hs_edge [64];

    always @(posedge clk) begin
        if (!rst_n) begin
            hs_cnt <= 0;
        end else if (op_valid && op_ready && hs_cnt < 64) begin
            hs_edge[hs_cnt] <= cyc;
            hs_cnt <= hs_cnt + 1;
        end
    end

    // Ready driver: 0 always high, 1 random, 2 low for first 3 valid cycles, 3 always low.
    int rmode = 0;
    initial begin
        int vcount;
        vcount = 0;
        forever begin
            @(negedge clk);
            #1;
            if (op_valid) vcount++; else vcount = 0;
            case (rmode)
                0: op_ready = 1'b1;
                1: op_ready = 1'($urandom % 2);
                2: op_ready = (vcount >= 4);
                default: op_ready = 1'b0;
            endcase
        end
    end

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 16; i++) ram[i] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cen", ram_cen, 1'b0);
        chk("rst_addr", ram_addr, 4'h0);
        chk("rst_valid", op_valid, 1'b0);
        chk("rst_code", op_code, 4'h0);
        chk("rst_data", op_data, 8'h00);
        chk("rst_pc", pc, 4'h0);
        chk("rst_halted", halted, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    initial begin
        int bad;
        logic [7:0] w;

        // LDA 9 with ready high: address sequence and 5-clock latency.
        fill(8'hF0); ram[0] = 8'h09; ram[9] = 8'h10; rmode = 0;
        do_reset();
        run(8);
        chk("t1_addr0", addr_log[0], 4'h0);
        chk("t1_addr1", addr_log[1], 4'h0);
        chk("t1_addr2", addr_log[2], 4'h0);
        chk("t1_addr3", addr_log[3], 4'h9);
        chk("t1_valid4", valid_log[4], 1'b1);
        chk("t1_code", code_log[4], 4'h0);
        chk("t1_data", data_log[4], 8'h10);
        chk("t1_pc", pc_log[4], 4'h1);
        chk("t1_valid5", valid_log[5], 1'b0);
        chk("t1_hs_cnt", hs_cnt, 1);
        chk("t1_hs_edge", hs_edge[0], 5);

        // ADD 10 with three stall cycles.
        fill(8'hF0); ram[0] = 8'h1A; ram[10] = 8'h14; rmode = 2;
        do_reset();
        run(12);
        chk("t2_valid3", valid_log[3], 1'b0);
        for (int i = 4; i < 8; i++) chk("t2_valid_hold", valid_log[i], 1'b1);
        chk("t2_valid8", valid_log[8], 1'b0);
        chk("t2_code_first", code_log[4], 4'h1);
        chk("t2_code_last", code_log[7], 4'h1);
        chk("t2_data_first", data_log[4], 8'h14);
        chk("t2_data_last", data_log[7], 8'h14);
        chk("t2_next_addr", addr_log[9], 4'h1);
        chk("t2_hs_edge", hs_edge[0], 8);

        // OUT then HLT.
        fill(8'hF0); ram[0] = 8'hE0; rmode = 0;
        do_reset();
        run(32);
        chk("t3_out_valid", valid_log[3], 1'b1);
        chk("t3_out_code", code_log[3], 4'hE);
        chk("t3_out_data", data_log[3], 8'h00);
        chk("t3_hs_edge", hs_edge[0], 4);
        chk("t3_not_halted", halt_log[3], 1'b0);
        bad = 0;
        for (int i = 8; i < 32; i++)
            if (!halt_log[i] || cen_log[i] || valid_log[i]) bad++;
        chk("t3_halt_quiet", bad, 0);
        chk("t3_hs_cnt", hs_cnt, 1);

        // PC wrap through a page of NOPs back onto OUT.
        fill(8'h30); ram[0] = 8'hE0; rmode = 0;
        do_reset();
        run(60);
        chk("t4_pc_before_wrap", pc_log[46], 4'hF);
        chk("t4_pc_wrapped", pc_log[47], 4'h0);
        chk("t4_pc_second", pc_log[50], 4'h1);
        chk("t4_addr_second", addr_log[50], 4'h0);
        chk("t4_hs_cnt", hs_cnt, 2);
        chk("t4_hs_edge", hs_edge[1], 53);

        // Asynchronous reset while an op is pending.
        fill(8'hF0); ram[0] = 8'h09; ram[9] = 8'h10; rmode = 3;
        do_reset();
        run(6);
        chk("t5_pending", op_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", op_valid, 1'b0);
        chk("t5_async_pc", pc, 4'h0);
        chk("t5_async_addr", ram_addr, 4'h0);
        rmode = 0;
        do_reset();
        run(8);
        chk("t5_restart_addr", addr_log[1], 4'h0);
        chk("t5_restart_oper", addr_log[3], 4'h9);
        chk("t5_restart_hs", hs_edge[0], 5);

        // Opcode 0x6: JMP when enabled, otherwise NOP.
        fill(8'hF0); ram[0] = 8'h65; ram[5] = 8'hE0; rmode = 0;
        do_reset();
        run(10);
`ifdef SAP1_FETCH_JMP_EN
        chk("t6_jmp_addr", addr_log[4], 4'h5);
        chk("t6_jmp_out", valid_log[6], 1'b1);
        chk("t6_jmp_code", code_log[6], 4'hE);
`else
        chk("t6_nop_addr", addr_log[4], 4'h1);
        chk("t6_nop_halt", halt_log[6], 1'b1);
`endif

        // Random programs with random back-pressure against the model.
        rmode = 1;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) begin
                w = 8'($urandom);
                case ($urandom % 8)
                    0: w[7:4] = 4'h0;
                    1: w[7:4] = 4'h1;
                    2: w[7:4] = 4'h2;
                    3: w[7:4] = 4'hE;
                    4: w[7:4] = 4'h6;
                    5: w[7:4] = 4'h3 + 4'($urandom % 3);
                    6: w[7:4] = ($urandom % 4 == 0) ? 4'hF : 4'h9;
                    default: w = w;
                endcase
                ram[i] = w;
            end
            do_reset();
            run(150);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
